pipe_reg_chain: RTL

// - Elastic, parametrised successor to the plain 32-bit flip-flop: Depth-stage register chain, Width-bit payload.
// - Per-stage valid bits, valid/ready handshake on both sides, synchronous flush.
// - Used between datapath stages (IF/ID, ID/EX, ...) of the pipelined MIPS core for stall/flush-aware staging.

---
 rtl/pipe_reg_chain.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_reg_chain.sv
// Elastic Depth-stage register chain with per-stage valid bits, valid/ready handshake and flush.
// Define PIPE_SKID_EN to add a one-entry input skid buffer and drive in_ready from a register.
module pipe_reg_chain #(
  parameter int unsigned      Width      = 32,
  parameter int unsigned      Depth      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [Width-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [Width-1:0]           out_data,
  output logic [$clog2(Depth+2)-1:0] occupancy
);

  localparam int unsigned OccW = $clog2(Depth + 2);

  logic [Depth-1:0] v_q;
  logic [Depth-1:0] v_nxt;
  logic [Depth-1:0] adv;
  logic [Width-1:0] d_q   [Depth];
  logic [Width-1:0] d_nxt [Depth];
  logic [OccW-1:0]  occ_nxt;
  logic             src_v;
  logic [Width-1:0] src_d;

`ifdef PIPE_SKID_EN
  logic             skid_v_q;
  logic             skid_v_nxt;
  logic             in_ready_q;
  logic [Width-1:0] skid_d_q;
  logic [Width-1:0] skid_d_nxt;

  assign in_ready = in_ready_q;
  // A parked skid entry always goes into stage 0 ahead of new input.
  assign src_v    = skid_v_q | (in_valid & in_ready);
  assign src_d    = skid_v_q ? skid_d_q : in_data;
`else
  assign in_ready = adv[0];
  assign src_v    = in_valid;
  assign src_d    = in_data;
`endif

  assign out_valid = v_q[Depth-1];
  assign out_data  = d_q[Depth-1];

  // Advance enables ripple back from the output so bubbles collapse.
  always_comb begin
    adv          = '0;
    adv[Depth-1] = !v_q[Depth-1] | out_ready;
    for (int i = int'(Depth) - 2; i >= 0; i--) begin
      adv[i] = !v_q[i] | adv[i+1];
    end
  end

  // Next-state: stage shifts, skid fill/drain, flush, occupancy.
  always_comb begin
    v_nxt = v_q;
    d_nxt = d_q;
`ifdef PIPE_SKID_EN
    skid_v_nxt = skid_v_q;
    skid_d_nxt = skid_d_q;
`endif
    occ_nxt = '0;

    if (adv[0]) begin
      v_nxt[0] = src_v;
      if (src_v) d_nxt[0] = src_d;
    end
    for (int unsigned i = 1; i < Depth; i++) begin
      if (adv[i]) begin
        v_nxt[i] = v_q[i-1];
        if (v_q[i-1]) d_nxt[i] = d_q[i-1];
      end
    end

`ifdef PIPE_SKID_EN
    if (skid_v_q && adv[0]) begin
      skid_v_nxt = 1'b0;
    end else if (in_valid && in_ready && !adv[0]) begin
      skid_v_nxt = 1'b1;
      skid_d_nxt = in_data;
    end
`endif

    if (flush) begin
      v_nxt = '0;
`ifdef PIPE_SKID_EN
      skid_v_nxt = 1'b0;
`endif
    end

    for (int unsigned i = 0; i < Depth; i++) begin
      occ_nxt = occ_nxt + OccW'(v_nxt[i]);
    end
`ifdef PIPE_SKID_EN
    occ_nxt = occ_nxt + OccW'(skid_v_nxt);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q       <= '0;
      occupancy <= '0;
      for (int unsigned i = 0; i < Depth; i++) d_q[i] <= ResetValue;
`ifdef PIPE_SKID_EN
      skid_v_q   <= 1'b0;
      skid_d_q   <= ResetValue;
      in_ready_q <= 1'b1;
`endif
    end else begin
      v_q       <= v_nxt;
      d_q       <= d_nxt;
      occupancy <= occ_nxt;
`ifdef PIPE_SKID_EN
      skid_v_q   <= skid_v_nxt;
      skid_d_q   <= skid_d_nxt;
      in_ready_q <= !skid_v_nxt;
`endif
    end
  end

endmodule
